// File: rtl/rose_ack_gen.sv
// Rise detector and delayed acknowledge generator: answers each sampled rise of
// signal_0 with a PULSE_W-cycle high on signal_1, DELAY sampling edges later.
// Optional rise statistics counter enabled by defining ROSE_ACK_STATS_EN.
module rose_ack_gen #(
  parameter int DELAY   = 2,
  parameter int PULSE_W = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       signal_0,
  output logic       signal_1,
  output logic       rise_det,
  output logic [3:0] inflight,
  output logic [7:0] rise_cnt
);

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_W);
  localparam logic [3:0] INFL_MAX   = 4'(DELAY);

  logic       s0_q;
  logic       rise;
  logic       flag_exit;
  logic [3:0] pulse_cnt_q;
  logic [3:0] pulse_cnt_d;
  logic [3:0] inflight_d;

  assign rise = en && signal_0 && !s0_q;

  // The last delay stage is the pulse counter load itself, so only DELAY-1
  // flag registers are needed ahead of it; DELAY=1 loads straight from the rise.
  generate
    if (DELAY == 1) begin : g_no_line
      assign flag_exit = rise;
    end else begin : g_line
      logic [DELAY-2:0] line_q;

      // NOTE: the delay line is a handful of flops, not a RAM, so it is reset
      // along with everything else; stale flags must never survive a reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          line_q <= '0;
        end else begin
          line_q <= (line_q << 1) | (DELAY - 1)'(rise);
        end
      end

      assign flag_exit = line_q[DELAY-2];
    end
  endgenerate

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    inflight_d  = inflight;
    if (flag_exit) begin
      pulse_cnt_d = PULSE_LOAD;
    end else if (pulse_cnt_q != 4'd0) begin
      pulse_cnt_d = pulse_cnt_q - 4'd1;
    end
    if (rise && !flag_exit && inflight != INFL_MAX) begin
      inflight_d = inflight + 4'd1;
    end else if (flag_exit && !rise && inflight != 4'd0) begin
      inflight_d = inflight - 4'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= 1'b0;
      rise_det    <= 1'b0;
      pulse_cnt_q <= 4'd0;
      signal_1    <= 1'b0;
      inflight    <= 4'd0;
    end else begin
      s0_q        <= signal_0;
      rise_det    <= rise;
      pulse_cnt_q <= pulse_cnt_d;
      signal_1    <= (pulse_cnt_d != 4'd0);
      inflight    <= inflight_d;
    end
  end

`ifdef ROSE_ACK_STATS_EN
  logic [7:0] rise_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_cnt_q <= 8'd0;
    end else if (rise && rise_cnt_q != 8'hFF) begin
      rise_cnt_q <= rise_cnt_q + 8'd1;
    end
  end

  assign rise_cnt = rise_cnt_q;
`else
  assign rise_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rose_ack_gen.sv
// Self-checking bench for rose_ack_gen: three parameterisations share one
// stimulus stream and are compared every cycle against a list-of-rises model.
module tb_rose_ack_gen;

  localparam int N = 3;
  localparam int DL [N] = '{2, 1, 4};
  localparam int PW [N] = '{1, 2, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       signal_0;
  logic       s1  [N];
  logic       rd  [N];
  logic [3:0] inf [N];
  logic [7:0] rc  [N];

  int checks = 0;
  int errors = 0;

  // Model state: edges at which rises were detected since the last reset.
  int rises[$];
  int edge_no = 0;
  bit prev_s0 = 1'b0;
  int n_rise = 0;

  always #5 clk = ~clk;

  rose_ack_gen #(.DELAY(2), .PULSE_W(1)) u_d2w1 (
    .clk(clk), .rst(rst), .en(en), .signal_0(signal_0),
    .signal_1(s1[0]), .rise_det(rd[0]), .inflight(inf[0]), .rise_cnt(rc[0]));

  rose_ack_gen #(.DELAY(1), .PULSE_W(2)) u_d1w2 (
    .clk(clk), .rst(rst), .en(en), .signal_0(signal_0),
    .signal_1(s1[1]), .rise_det(rd[1]), .inflight(inf[1]), .rise_cnt(rc[1]));

  rose_ack_gen #(.DELAY(4), .PULSE_W(3)) u_d4w3 (
    .clk(clk), .rst(rst), .en(en), .signal_0(signal_0),
    .signal_1(s1[2]), .rise_det(rd[2]), .inflight(inf[2]), .rise_cnt(rc[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
    end
  endtask

  // Apply one sampling edge to the model.
  task automatic model_edge(input bit r, input bit e, input bit s0);
    edge_no++;
    if (r) begin
      rises.delete();
      prev_s0 = 1'b0;
      n_rise  = 0;
    end else begin
      if (s0 && !prev_s0 && e) begin
        rises.push_back(edge_no);
        n_rise++;
      end
      prev_s0 = s0;
    end
    while (rises.size() > 0 && rises[0] + 24 < edge_no) void'(rises.pop_front());
  endtask

  // Output value visible after edge_no: a rise at k is high when sampled at
  // edges k+D .. k+D+W-1, i.e. it is driven after edges k+D-1 .. k+D+W-2.
  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      bit   e_sig = 1'b0;
      bit   e_det = 1'b0;
      int   e_inf = 0;
      int   e_cnt;
      foreach (rises[j]) begin
        int k = rises[j];
        if (k + DL[i] - 1 <= edge_no && edge_no <= k + DL[i] + PW[i] - 2) e_sig = 1'b1;
        if (k == edge_no) e_det = 1'b1;
        if (k <= edge_no && edge_no < k + DL[i] - 1) e_inf++;
      end
`ifdef ROSE_ACK_STATS_EN
      e_cnt = (n_rise > 255) ? 255 : n_rise;
`else
      e_cnt = 0;
`endif
      check($sformatf("signal_1[%0d]", i), 32'(s1[i]),  32'(e_sig));
      check($sformatf("rise_det[%0d]", i), 32'(rd[i]),  32'(e_det));
      check($sformatf("inflight[%0d]", i), 32'(inf[i]), 32'(e_inf));
      check($sformatf("rise_cnt[%0d]", i), 32'(rc[i]),  32'(e_cnt));
    end
  endtask

  // Drive inputs away from the edge, let one posedge pass, check on negedge.
  task automatic do_cycle(input bit r, input bit e, input bit s0);
    rst      = r;
    en       = e;
    signal_0 = s0;
    @(posedge clk);
    model_edge(r, e, s0);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; signal_0 = 1'b0;
    do_cycle(1, 0, 0);
    do_cycle(1, 0, 0);

    // Single rise, then quiet.
    do_cycle(0, 1, 0);
    do_cycle(0, 1, 1);
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0);

    // Two rises two edges apart: merged pulses on the wider instances.
    do_cycle(0, 1, 1);
    do_cycle(0, 1, 0);
    do_cycle(0, 1, 1);
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0);

    // Enable gating, then an enabled rise; a level high while gated is not a rise later.
    do_cycle(0, 0, 1);
    do_cycle(0, 0, 1);
    do_cycle(0, 1, 1);
    do_cycle(0, 1, 0);
    do_cycle(0, 1, 1);
    do_cycle(0, 0, 0);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 0);

    // Reset mid-flight with signal_0 held high: rise re-detected after reset.
    do_cycle(0, 1, 1);
    do_cycle(1, 1, 1);
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 1);
    do_cycle(0, 1, 0);

    // Level held for ten edges: a single response.
    do_cycle(1, 1, 0);
    for (int i = 0; i < 10; i++) do_cycle(0, 1, 1);
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0);

    // Random traffic with occasional resets and enable drops.
    for (int i = 0; i < 600; i++)
      do_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));

    // Dense rises without reset to drive the statistics counter into saturation.
    do_cycle(1, 1, 0);
    for (int i = 0; i < 700; i++) do_cycle(0, 1, i[0]);
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
